// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB/BRJ over a shared
// ALU and unified memory, with a memory-ready handshake and wait-state timeout.
module multicycle_control_unit #(
  parameter int OPCODE_W = 3,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                pc_wr,
  output logic                ir_wr,
  output logic                i_or_d,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                reg_wr,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_dest,
  output logic [1:0]          mem_to_reg,
  output logic                sign_or_zero,
  output logic                illegal,
  output logic                mem_timeout,
  output logic                instr_done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRJ    = 3'd5
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_IMM  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_op;
  logic             w_illegal;
  logic             w_wait;
  logic             w_tmo;

  assign w_op      = opcode[2:0];
  assign w_illegal = (opcode >> 3) != '0;
  assign w_wait    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_tmo     = (TIMEOUT > 0) && w_wait && (r_cnt == CNT_W'(TIMEOUT));
  assign state     = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Counts consecutive not-ready cycles; any handshake, state change or abort clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_wait && !w_tmo) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    pc_wr        = 1'b0;
    ir_wr        = 1'b0;
    i_or_d       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_wr       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    pc_src       = 2'b00;
    reg_dest     = 2'b00;
    mem_to_reg   = 2'b00;
    sign_or_zero = (opcode != OPCODE_W'(1));
    illegal      = 1'b0;
    mem_timeout  = 1'b0;
    instr_done   = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (w_illegal) begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end else if ((w_op == OP_J) || (w_op == OP_JAL) || (w_op == OP_BEQ)) begin
          w_next = S_BRJ;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (w_op)
          OP_R:          begin alu_src_b = 2'b00; alu_op = 2'b00; w_next = S_WB;  end
          OP_IMM:        begin alu_src_b = 2'b10; alu_op = 2'b10; w_next = S_WB;  end
          OP_ADDI:       begin alu_src_b = 2'b10; alu_op = 2'b11; w_next = S_WB;  end
          OP_LW, OP_SW:  begin alu_src_b = 2'b10; alu_op = 2'b11; w_next = S_MEM; end
          default:       w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        mem_rd = (w_op == OP_LW);
        mem_wr = (w_op == OP_SW);
        if (mem_ready) begin
          if (w_op == OP_LW) begin
            w_next = S_WB;
          end else begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        reg_dest   = (w_op == OP_R)  ? 2'b01 : 2'b00;
        mem_to_reg = (w_op == OP_LW) ? 2'b01 : 2'b00;
        w_next     = S_FETCH;
      end
      S_BRJ: begin
        instr_done = 1'b1;
        w_next     = S_FETCH;
        case (w_op)
          OP_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            pc_wr     = zero;
          end
          OP_J: begin
            pc_src = 2'b10;
            pc_wr  = 1'b1;
          end
          OP_JAL: begin
            pc_src     = 2'b10;
            pc_wr      = 1'b1;
            reg_wr     = 1'b1;
            reg_dest   = 2'b10;
            mem_to_reg = 2'b10;
          end
          default: ;
        endcase
      end
      default: w_next = S_FETCH;
    endcase

    // Abort leaves mem_rd/mem_wr as in the waiting state but suppresses every write-back.
    if (w_tmo) begin
      mem_timeout = 1'b1;
      w_next      = S_FETCH;
      pc_wr       = 1'b0;
      ir_wr       = 1'b0;
      reg_wr      = 1'b0;
      instr_done  = 1'b0;
    end

    if (!rst_n) begin
      pc_wr       = 1'b0;
      ir_wr       = 1'b0;
      i_or_d      = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      reg_wr      = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_src      = 2'b00;
      reg_dest    = 2'b00;
      mem_to_reg  = 2'b00;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      instr_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: each instruction is expanded into an expected
// per-cycle trace (inputs to drive plus outputs to expect) and replayed against the DUT.
module tb_multicycle_control_unit;

  localparam int OPW = 4;
  localparam int TMO = 15;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] reg_dest;
    logic [1:0] mem_to_reg;
    logic       sign_or_zero;
    logic       illegal;
    logic       mem_timeout;
    logic       instr_done;
  } outs_t;

  typedef struct {
    logic       mr;
    logic [2:0] st;
    outs_t      o;
  } step_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic [2:0]     state;
  logic pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src, reg_dest, mem_to_reg;
  logic sign_or_zero, illegal, mem_timeout, instr_done;

  int    n_chk  = 0;
  int    n_fail = 0;
  step_t q[$];

  multicycle_control_unit #(.OPCODE_W(OPW), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_wr(pc_wr), .ir_wr(ir_wr), .i_or_d(i_or_d), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .reg_wr(reg_wr), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
    .sign_or_zero(sign_or_zero), .illegal(illegal), .mem_timeout(mem_timeout),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  function automatic outs_t observe();
    outs_t o;
    o.pc_wr = pc_wr; o.ir_wr = ir_wr; o.i_or_d = i_or_d; o.mem_rd = mem_rd;
    o.mem_wr = mem_wr; o.reg_wr = reg_wr; o.alu_src_a = alu_src_a;
    o.alu_src_b = alu_src_b; o.alu_op = alu_op; o.pc_src = pc_src;
    o.reg_dest = reg_dest; o.mem_to_reg = mem_to_reg; o.sign_or_zero = sign_or_zero;
    o.illegal = illegal; o.mem_timeout = mem_timeout; o.instr_done = instr_done;
    return o;
  endfunction

  function automatic outs_t base(input logic [OPW-1:0] op);
    outs_t o = '0;
    o.sign_or_zero = (op != 4'd1);
    return o;
  endfunction

  task automatic check(input logic [2:0] est, input outs_t eo, input string tag);
    outs_t obs = observe();
    n_chk++;
    assert (state === est) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, est);
    end
    n_chk++;
    assert (obs === eo) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %h expected %h", tag, obs, eo);
    end
  endtask

  // Expected trace for one instruction given fetch wait cycles fw and memory wait cycles mw.
  task automatic build(input logic [OPW-1:0] op, input int fw, input int mw, input logic zf);
    step_t      s;
    logic [2:0] lo  = op[2:0];
    logic       ill = op[3];
    q.delete();
    for (int i = 0; i < fw; i++) begin
      s.mr = 1'b0; s.st = 3'd0; s.o = base(op);
      s.o.mem_rd = 1'b1; s.o.alu_src_b = 2'b01;
      s.o.mem_timeout = ((i % (TMO + 1)) == TMO);
      q.push_back(s);
    end
    s.mr = 1'b1; s.st = 3'd0; s.o = base(op);
    s.o.mem_rd = 1'b1; s.o.alu_src_b = 2'b01; s.o.ir_wr = 1'b1; s.o.pc_wr = 1'b1;
    q.push_back(s);

    s.mr = 1'($urandom); s.st = 3'd1; s.o = base(op); s.o.alu_src_b = 2'b11;
    if (ill) begin
      s.o.illegal = 1'b1;
      q.push_back(s);
      return;
    end
    q.push_back(s);

    if (lo == 3'd2 || lo == 3'd3 || lo == 3'd6) begin
      s.mr = 1'($urandom); s.st = 3'd5; s.o = base(op); s.o.instr_done = 1'b1;
      if (lo == 3'd6) begin
        s.o.alu_src_a = 1'b1; s.o.alu_op = 2'b01; s.o.pc_src = 2'b01; s.o.pc_wr = zf;
      end else begin
        s.o.pc_src = 2'b10; s.o.pc_wr = 1'b1;
        if (lo == 3'd3) begin
          s.o.reg_wr = 1'b1; s.o.reg_dest = 2'b10; s.o.mem_to_reg = 2'b10;
        end
      end
      q.push_back(s);
      return;
    end

    s.mr = 1'($urandom); s.st = 3'd2; s.o = base(op); s.o.alu_src_a = 1'b1;
    s.o.alu_src_b = (lo == 3'd0) ? 2'b00 : 2'b10;
    s.o.alu_op    = (lo == 3'd0) ? 2'b00 : (lo == 3'd1) ? 2'b10 : 2'b11;
    q.push_back(s);

    if (lo == 3'd4 || lo == 3'd5) begin
      for (int i = 0; i < mw; i++) begin
        s.mr = 1'b0; s.st = 3'd3; s.o = base(op);
        s.o.i_or_d = 1'b1; s.o.mem_rd = (lo == 3'd4); s.o.mem_wr = (lo == 3'd5);
        if (i == TMO) begin
          s.o.mem_timeout = 1'b1;
          q.push_back(s);
          return;
        end
        q.push_back(s);
      end
      s.mr = 1'b1; s.st = 3'd3; s.o = base(op);
      s.o.i_or_d = 1'b1; s.o.mem_rd = (lo == 3'd4); s.o.mem_wr = (lo == 3'd5);
      if (lo == 3'd5) begin
        s.o.instr_done = 1'b1;
        q.push_back(s);
        return;
      end
      q.push_back(s);
    end

    s.mr = 1'($urandom); s.st = 3'd4; s.o = base(op);
    s.o.reg_wr = 1'b1; s.o.instr_done = 1'b1;
    s.o.reg_dest   = (lo == 3'd0) ? 2'b01 : 2'b00;
    s.o.mem_to_reg = (lo == 3'd4) ? 2'b01 : 2'b00;
    q.push_back(s);
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic run(input int id, input logic [OPW-1:0] op, input int fw, input int mw,
                     input logic zf, input bit abort_in_exec);
    build(op, fw, mw, zf);
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) begin
        opcode = op;
        zero   = zf;
      end
      mem_ready = q[i].mr;
      @(negedge clk);
      check(q[i].st, q[i].o, $sformatf("i%0d_op%0h_c%0d", id, op, i));
      if (abort_in_exec && q[i].st == 3'd2) begin
        #2 rst_n = 1'b0;
        #1 check(3'd0, base(op), $sformatf("i%0d_async_rst", id));
        @(posedge clk);
        #1 check(3'd0, base(op), $sformatf("i%0d_rst_held", id));
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [OPW-1:0] op;
    int             r, fw, mw;
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(3'd0, base(4'd0), "reset_op0");
    opcode = 4'd1;
    #1 check(3'd0, base(4'd1), "reset_op1");
    @(posedge clk);
    #1 rst_n = 1'b1;

    run(0, 4'b0000, 0, 0,  1'b0, 1'b0);
    run(1, 4'b0100, 0, 2,  1'b0, 1'b0);
    run(2, 4'b0110, 0, 0,  1'b1, 1'b0);
    run(3, 4'b0110, 0, 0,  1'b0, 1'b0);
    run(4, 4'b0011, 0, 0,  1'b0, 1'b0);
    run(5, 4'b0101, 0, 20, 1'b0, 1'b0);
    run(6, 4'b0100, 1, 16, 1'b0, 1'b0);
    run(7, 4'b1000, 0, 0,  1'b0, 1'b0);
    run(8, 4'b0001, 18, 0, 1'b0, 1'b0);
    run(9, 4'b0111, 0, 0,  1'b0, 1'b0);
    run(10, 4'b0010, 0, 0, 1'b0, 1'b0);
    run(11, 4'b0000, 0, 0, 1'b0, 1'b1);
    run(12, 4'b0101, 0, 15, 1'b0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      r  = int'($urandom_range(0, 8));
      op = (r == 8) ? OPW'(8 + $urandom_range(0, 7)) : OPW'(r);
      fw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0)  ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      run(100 + k, op, fw, mw, 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- An FSM sequences each instruction through FETCH/DECODE/EXEC/MEM/WB/BRJ, so the datapath can share one ALU and one unified memory.
- Adds a ready handshake to memory, a wait-state timeout, an illegal-opcode flag and an instruction-retire pulse.
- Sits between the instruction register (opcode source) and the shared datapath muxes and enables.

Parameters:
OPCODE_W, 3, opcode width; opcodes with any bit above bit 2 set are illegal.
TIMEOUT, 15, max consecutive mem_ready-low cycles in FETCH/MEM before abort; 0 disables the timeout.
CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  OPCODE_W  opcode from instruction register; stable from DECODE onward.
zero  in  1  ALU zero flag, used in BRJ for beq.
mem_ready  in  1  memory has completed the current read/write this cycle.
state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRJ=5.
pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr  out  1 each  datapath enables and address select.
alu_src_a  out  1  0=PC, 1=rs.
alu_src_b  out  2  00=rt, 01=const 4, 10=imm, 11=imm<<2.
alu_op  out  2  ALU function class.
pc_src  out  2  00=ALU result, 01=ALU-out register (branch target), 10=jump target.
reg_dest, mem_to_reg  out  2 each  register-file write address and write-data selects.
sign_or_zero  out  1  0=zero-extend immediate, 1=sign-extend.
illegal  out  1  one-cycle pulse in DECODE on an illegal opcode.
mem_timeout  out  1  one-cycle pulse on the abort cycle.
instr_done  out  1  one-cycle pulse on the last cycle of each completed instruction.

Behaviour:
- Opcode map: 000 R-type; 001 imm ALU, zero-extended; 010 j; 011 jal; 100 lw; 101 sw; 110 beq; 111 addi.
- Default output values in every state: all outputs 0 except sign_or_zero, which is 0 for opcode 001 and 1 otherwise.
- Reset: state=FETCH.
  - While rst_n=0, every output is 0 except sign_or_zero and state.
  - mem_rd is gated by rst_n.
  - The timeout counter is cleared to 0.
- FETCH:
  - Drives mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_wr=pc_wr=mem_ready (Mealy).
  - On mem_ready=1 go to DECODE; otherwise stay.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 to precompute the branch target.
  - Next state: 000/001/100/101/111 -> EXEC; 010/011/110 -> BRJ.
  - Illegal opcode: illegal=1, go to FETCH, instr_done=0.
- EXEC: alu_src_a=1.
  - 000: alu_src_b=00, alu_op=00 -> WB.
  - 001: alu_src_b=10, alu_op=10 -> WB.
  - 111: alu_src_b=10, alu_op=11 -> WB.
  - 100/101: alu_src_b=10, alu_op=11 -> MEM.
- MEM: i_or_d=1; lw drives mem_rd=1, sw drives mem_wr=1.
  - Held until mem_ready=1.
  - Then lw -> WB; sw -> FETCH with instr_done=1.
- WB: reg_wr=1 for exactly one cycle, instr_done=1, then -> FETCH.
  - reg_dest=01 for R-type, 00 otherwise.
  - mem_to_reg=01 for lw, 00 otherwise.
- BRJ: instr_done=1, then -> FETCH.
  - beq: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_wr=zero.
  - j: pc_src=10, pc_wr=1.
  - jal: pc_src=10, pc_wr=1, reg_wr=1, reg_dest=10, mem_to_reg=10.
- Latency with zero wait states:
  - R-type/001/111/sw: 4 cycles.
  - lw: 5 cycles.
  - beq/j/jal: 3 cycles.
  - Each cycle of mem_ready=0 adds one cycle.
- Timeout counter:
  - Increments each cycle in FETCH/MEM with mem_ready=0.
  - Clears on any state change and whenever mem_ready=1.
  - When the counter equals TIMEOUT and mem_ready=0 (TIMEOUT>0): mem_timeout=1, go to FETCH, with pc_wr/ir_wr/reg_wr forced 0 that cycle; mem_wr stays as in MEM.
  - mem_ready=1 on the same cycle the counter hits TIMEOUT: completion wins, no timeout.
- Async reset mid-instruction: immediate return to FETCH, no write enable asserted after rst_n falls. The first fetch occurs on the first clock after release.
- Encodings 6 and 7 of state are unreachable; if entered, go to FETCH on the next clock.

Test Plan:
- Reset release, mem_ready=1, opcode=000 -> states 0,1,2,4; ir_wr/pc_wr=1 at cycle 0; reg_wr=1, reg_dest=01, instr_done=1 at cycle 3; back to FETCH at cycle 4.
- opcode=100, mem_ready low 2 cycles in MEM -> sequence 0,1,2,3,3,3,4; mem_rd=1, i_or_d=1 through MEM; WB has mem_to_reg=01, reg_wr=1; total 7 cycles.
- opcode=110: zero=1 gives pc_wr=1, pc_src=01 in BRJ; repeat with zero=0 gives pc_wr=0; both take 3 cycles with instr_done=1.
- opcode=011 -> BRJ with pc_wr=1, reg_wr=1, reg_dest=10, mem_to_reg=10, pc_src=10.
- TIMEOUT=15, mem_ready held 0 in MEM for sw -> mem_timeout pulses on the 16th MEM cycle, state -> FETCH, instr_done=0, no reg_wr.
- OPCODE_W=4, opcode=4'b1000 -> illegal=1 in DECODE, next state FETCH; rst_n pulsed low during EXEC -> state=0 immediately, all enables 0.
